// File: rtl/ex_mem_reg_if.sv
// EX -> MEM stage bundle: ex_* fields are driven by EX, mem_* fields by the
// EX/MEM pipeline register.
interface ex_mem_reg_if #(
    parameter int unsigned XLEN = 32
);
    logic            ex_valid_i;
    logic [XLEN-1:0] ex_pc_i;
    logic [XLEN-1:0] ex_alu_result_i;
    logic [XLEN-1:0] ex_rs2_data_i;
    logic [4:0]      ex_rd_i;
    logic            ex_reg_wen_i;
    logic            ex_mem_wen_i;
    logic            ex_mem_ren_i;
    logic [1:0]      ex_wb_sel_i;
    logic [2:0]      ex_funct3_i;

    logic            mem_valid_o;
    logic [XLEN-1:0] mem_pc_o;
    logic [XLEN-1:0] mem_alu_result_o;
    logic [XLEN-1:0] mem_rs2_data_o;
    logic [4:0]      mem_rd_o;
    logic            mem_reg_wen_o;
    logic            mem_mem_wen_o;
    logic            mem_mem_ren_o;
    logic [1:0]      mem_wb_sel_o;
    logic [2:0]      mem_funct3_o;

    modport master (
        output ex_valid_i, ex_pc_i, ex_alu_result_i, ex_rs2_data_i, ex_rd_i,
               ex_reg_wen_i, ex_mem_wen_i, ex_mem_ren_i, ex_wb_sel_i, ex_funct3_i,
        input  mem_valid_o, mem_pc_o, mem_alu_result_o, mem_rs2_data_o, mem_rd_o,
               mem_reg_wen_o, mem_mem_wen_o, mem_mem_ren_o, mem_wb_sel_o, mem_funct3_o
    );

    modport slave (
        input  ex_valid_i, ex_pc_i, ex_alu_result_i, ex_rs2_data_i, ex_rd_i,
               ex_reg_wen_i, ex_mem_wen_i, ex_mem_ren_i, ex_wb_sel_i, ex_funct3_i,
        output mem_valid_o, mem_pc_o, mem_alu_result_o, mem_rs2_data_o, mem_rd_o,
               mem_reg_wen_o, mem_mem_wen_o, mem_mem_ren_o, mem_wb_sel_o, mem_funct3_o
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall hold, flush bubble, x0 write suppression
// and a saturating count of bubbles entering MEM.
module ex_mem_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               flush_i,
    ex_mem_reg_if.slave        bus,
    output logic [CNT_W-1:0]   bubble_cnt_o
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] rs2_data;
        logic [4:0]      rd;
        logic            reg_wen;
        logic            mem_wen;
        logic            mem_ren;
        logic [1:0]      wb_sel;
        logic [2:0]      funct3;
    } stage_t;

    stage_t            stage_d, stage_q;
    logic [CNT_W-1:0]  bubble_cnt_q;
    logic              load_en;

    // Flush overrides stall; a bubble is the all-zero stage.
    assign load_en = flush_i || !stall_i;

    always_comb begin
        stage_d = '0;
        if (!flush_i && bus.ex_valid_i) begin
            stage_d.valid      = 1'b1;
            stage_d.pc         = bus.ex_pc_i;
            stage_d.alu_result = bus.ex_alu_result_i;
            stage_d.rs2_data   = bus.ex_rs2_data_i;
            stage_d.rd         = bus.ex_rd_i;
            // Writes to x0 never leave EX, so hazard logic can compare rd blindly.
            stage_d.reg_wen    = bus.ex_reg_wen_i && (bus.ex_rd_i != 5'd0);
            stage_d.mem_wen    = bus.ex_mem_wen_i;
            stage_d.mem_ren    = bus.ex_mem_ren_i;
            stage_d.wb_sel     = bus.ex_wb_sel_i;
            stage_d.funct3     = bus.ex_funct3_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q      <= '0;
            bubble_cnt_q <= '0;
        end else if (load_en) begin
            stage_q <= stage_d;
            if (!stage_d.valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.mem_valid_o      = stage_q.valid;
    assign bus.mem_pc_o         = stage_q.pc;
    assign bus.mem_alu_result_o = stage_q.alu_result;
    assign bus.mem_rs2_data_o   = stage_q.rs2_data;
    assign bus.mem_rd_o         = stage_q.rd;
    assign bus.mem_reg_wen_o    = stage_q.reg_wen;
    assign bus.mem_mem_wen_o    = stage_q.mem_wen;
    assign bus.mem_mem_ren_o    = stage_q.mem_ren;
    assign bus.mem_wb_sel_o     = stage_q.wb_sel;
    assign bus.mem_funct3_o     = stage_q.funct3;
    assign bubble_cnt_o         = bubble_cnt_q;
endmodule
